proc_seq_multi: RTL
===================

// Module: proc_seq_multi
// PURPOSE
//  Packet-processing sequencer for an N-stage match-action pipeline: parser once, then per enabled stage
//  match -> execute (hit/miss action address per stage). One shared executor; early exit on drop.
//  Adds a per-wait watchdog, error state and packet/error counters. Sits between top-level packet I/O and
//  parser/matcher[k]/executor instances, which live outside this block and connect by ports.
// PARAMETERS
//  NUM_STAGES   4     number of match stages (1..8)
//  ADDR_W       32    action-address width (ex_op_start_cnt_o)
//  TIMEOUT_CYC  1024  max cycles waiting on any ready; 0 disables the watchdog
//  CNT_W        32    width of statistics counters
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  start_i        in   1             level request; held high until ready_o/error_o is seen, then dropped
//  ready_o        out  1             packet finished OK; held until start_i low
//  drop_o         out  1             valid with ready_o: executor requested drop
//  error_o        out  1             watchdog fired; held until start_i low
//  ps_start_o     out  1             parser start (level)
//  ps_ready_i     in   1             parser done
//  mt_start_o     out  NUM_STAGES    one-hot matcher start (level)
//  mt_ready_i     in   NUM_STAGES    matcher done, per stage
//  mt_is_match_i  in   NUM_STAGES    hit flag, sampled with mt_ready_i[k]
//  ex_start_o     out  1             executor start (level)
//  ex_stage_o     out  $clog2(NUM_STAGES)  stage index for arg muxing; valid with ex_start_o
//  ex_op_start_cnt_o out ADDR_W      selected action address
//  ex_ready_i     in   1             executor done
//  ex_drop_i      in   1             sampled with ex_ready_i
//  cfg_we_i       in   1             config write request (level, hold until ack)
//  cfg_stage_i    in   $clog2(NUM_STAGES)  target stage
//  cfg_en_i       in   1             stage enable
//  cfg_hit_addr_i in   ADDR_W        hit action address
//  cfg_miss_addr_i in  ADDR_W        miss action address
//  cfg_ack_o      out  1             1-cycle pulse: write applied
//  pkt_cnt_o      out  CNT_W         packets completed (ready_o rises), wraps
//  err_cnt_o      out  CNT_W         watchdog events, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0. Stage table: en=0, hit=miss=0. State FREE, stage index 0, watchdog 0.
//  States: FREE, PARSE, MATCH, EXEC, DONE, ERR.
//  FREE: cfg_we_i has priority over start_i. The table is written, and cfg_ack_o pulses the next cycle.
//        If both are high, cfg is taken first; start is taken the cycle after the ack (start_i still high).
//        Otherwise start_i=1 -> ps_start_o<=1, ready_o/drop_o/error_o<=0, k<=0 -> PARSE.
//        cfg_we_i outside FREE: ignored, no ack. The requester holds cfg_we_i until FREE.
//        cfg_we_i while cfg_ack_o is high (same request, held one more cycle): no second write.
//  PARSE: on ps_ready_i, ps_start_o<=0. k<=first enabled stage, then MATCH with mt_start_o[k]<=1.
//        If no stage is enabled: DONE, ready_o<=1, drop_o<=0.
//  MATCH: on mt_ready_i[k] (other bits ignored), mt_start_o<=0 and ex_start_o<=1.
//        ex_stage_o<=k; ex_op_start_cnt_o<=hit[k] if mt_is_match_i[k], else miss[k] -> EXEC.
//  EXEC: on ex_ready_i, ex_start_o<=0.
//        If ex_drop_i, or no enabled stage exists above k: DONE, ready_o<=1, drop_o<=ex_drop_i, pkt_cnt++.
//        Otherwise k<=next enabled stage, mt_start_o[k]<=1 -> MATCH.
//  DONE/ERR: when start_i=0, clear ready_o/drop_o/error_o -> FREE.
//  Latency: each ready -> next start is exactly 1 cycle. Min packet = 2 + 2*enabled stages cycles + externals.
//  Watchdog: cleared on every state change. Increments each cycle in PARSE/MATCH/EXEC.
//        Reaching TIMEOUT_CYC: all starts<=0, error_o<=1, err_cnt++ (saturating) -> ERR.
//        A ready arriving on the timeout cycle wins (no error).
//  Start dropped mid-packet: ignored; the sequence completes. rst mid-packet: immediate return to reset values.
//  Stage table is read only in FREE-decoupled states but written only in FREE, so it is stable per packet.
// STRUCTURE
//  Package proc_seq_pkg: state enum, stage_cfg_t struct {en, hit_addr, miss_addr}, helper function
//    next_enabled(en_vec, from_idx) returning {found, idx}.
//  Sub-module proc_watchdog (count/clear/enable, TIMEOUT_CYC param, expired output).
//  Stage table is a flat register array inside this module.
// TESTING
//  1. Cfg stage0 en hit=0x10 miss=0x20. Packet with mt_is_match=1 -> ex_op_start_cnt_o=0x10, ready_o, pkt_cnt=1.
//  2. Stages 0,2 enabled, 1 disabled. Stage0 miss, stage2 hit -> addrs 0x20 then stage2 hit.
//     ex_stage_o=0 then 2; mt_start_o[1] never asserted.
//  3. Executor drops on stage0 (4 stages enabled) -> DONE with drop_o=1; no mt_start_o[1..3] asserted.
//  4. TIMEOUT_CYC=8, matcher never ready -> error_o at 8th cycle of MATCH, starts low, err_cnt=1.
//     start_i low -> FREE; the next packet works.
//  5. cfg_we_i raised during EXEC -> no ack until FREE; then ack 1 cycle. The packet in flight uses old addresses.
//  6. No stages enabled -> ready_o 1 cycle after ps_ready_i; rst mid-MATCH -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// Shared types and helpers for the match-action packet sequencer.
package proc_seq_pkg;

  typedef enum logic [2:0] {
    S_FREE,
    S_PARSE,
    S_MATCH,
    S_EXEC,
    S_DONE,
    S_ERR
  } state_t;

  localparam int TBL_ADDR_W = 32;

  typedef struct packed {
    logic                  en;
    logic [TBL_ADDR_W-1:0] hit_addr;
    logic [TBL_ADDR_W-1:0] miss_addr;
  } stage_cfg_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } next_t;

  function automatic int stage_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest enabled stage at or above from_idx; tables are at most 8 stages deep.
  function automatic next_t next_enabled(input logic [7:0] en_vec, input logic [3:0] from_idx);
    next_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (en_vec[i] && (4'(i) >= from_idx)) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/proc_seq_if.sv
// Handshakes between the sequencer and the external parser, matchers and executor.
interface proc_seq_if #(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = 32
);
  import proc_seq_pkg::*;
  localparam int SW = stage_w(NUM_STAGES);

  logic                  ps_start_o;
  logic                  ps_ready_i;
  logic [NUM_STAGES-1:0] mt_start_o;
  logic [NUM_STAGES-1:0] mt_ready_i;
  logic [NUM_STAGES-1:0] mt_is_match_i;
  logic                  ex_start_o;
  logic [SW-1:0]         ex_stage_o;
  logic [ADDR_W-1:0]     ex_op_start_cnt_o;
  logic                  ex_ready_i;
  logic                  ex_drop_i;

  modport master (
    output ps_start_o, mt_start_o, ex_start_o, ex_stage_o, ex_op_start_cnt_o,
    input  ps_ready_i, mt_ready_i, mt_is_match_i, ex_ready_i, ex_drop_i
  );

  modport slave (
    input  ps_start_o, mt_start_o, ex_start_o, ex_stage_o, ex_op_start_cnt_o,
    output ps_ready_i, mt_ready_i, mt_is_match_i, ex_ready_i, ex_drop_i
  );

endinterface

// File: rtl/proc_watchdog.sv
// Per-wait cycle counter; expired marks the cycle on which the wait budget is used up.
module proc_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // A zero budget disables the watchdog entirely.
  assign expired = (TIMEOUT_CYC != 0) && enable && (count == LAST);

endmodule

// File: rtl/proc_seq_multi.sv
// Packet sequencer: parse once, then match/execute each enabled stage, with watchdog and statistics.
module proc_seq_multi
  import proc_seq_pkg::*;
#(
  parameter  int NUM_STAGES  = 4,
  parameter  int ADDR_W      = 32,
  parameter  int TIMEOUT_CYC = 1024,
  parameter  int CNT_W       = 32,
  localparam int SW          = stage_w(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              ready_o,
  output logic              drop_o,
  output logic              error_o,
  proc_seq_if.master        eng,
  input  logic              cfg_we_i,
  input  logic [SW-1:0]     cfg_stage_i,
  input  logic              cfg_en_i,
  input  logic [ADDR_W-1:0] cfg_hit_addr_i,
  input  logic [ADDR_W-1:0] cfg_miss_addr_i,
  output logic              cfg_ack_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [SW-1:0]         kk;
  logic                  ps_d, ex_d;
  logic [NUM_STAGES-1:0] mt_d;
  logic [SW-1:0]         ex_stage_d;
  logic [ADDR_W-1:0]     ex_addr_d;
  logic                  ready_d, drop_d, error_d, ack_d;
  logic                  tbl_we, pkt_inc, err_inc;
  logic [7:0]            en_vec;
  next_t                 first, after;
  logic                  wd_expired, wd_clear, wd_enable;

  stage_cfg_t tbl [NUM_STAGES];

  assign kk        = SW'(k_q);
  assign wd_enable = (state_q == S_PARSE) || (state_q == S_MATCH) || (state_q == S_EXEC);
  assign wd_clear  = (state_d != state_q);

  always_comb begin
    en_vec = '0;
    for (int i = 0; i < NUM_STAGES; i++) en_vec[i] = tbl[i].en;
  end

  assign first = next_enabled(en_vec, 4'd0);
  assign after = next_enabled(en_vec, 4'(k_q) + 4'd1);

  proc_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ps_d       = eng.ps_start_o;
    mt_d       = eng.mt_start_o;
    ex_d       = eng.ex_start_o;
    ex_stage_d = eng.ex_stage_o;
    ex_addr_d  = eng.ex_op_start_cnt_o;
    ready_d    = ready_o;
    drop_d     = drop_o;
    error_d    = error_o;
    ack_d      = 1'b0;
    tbl_we     = 1'b0;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;

    unique case (state_q)
      S_FREE: begin
        // The ack cycle swallows the still-held write request.
        if (cfg_ack_o) begin
          ack_d = 1'b0;
        end else if (cfg_we_i) begin
          tbl_we = 1'b1;
          ack_d  = 1'b1;
        end else if (start_i) begin
          ps_d    = 1'b1;
          ready_d = 1'b0;
          drop_d  = 1'b0;
          error_d = 1'b0;
          k_d     = '0;
          state_d = S_PARSE;
        end
      end
      S_PARSE: begin
        if (eng.ps_ready_i) begin
          ps_d = 1'b0;
          if (first.found) begin
            k_d     = first.idx;
            mt_d    = NUM_STAGES'(1) << first.idx;
            state_d = S_MATCH;
          end else begin
            ready_d = 1'b1;
            drop_d  = 1'b0;
            pkt_inc = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MATCH: begin
        if (eng.mt_ready_i[kk]) begin
          mt_d       = '0;
          ex_d       = 1'b1;
          ex_stage_d = kk;
          ex_addr_d  = eng.mt_is_match_i[kk] ? ADDR_W'(tbl[kk].hit_addr)
                                             : ADDR_W'(tbl[kk].miss_addr);
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (eng.ex_ready_i) begin
          ex_d = 1'b0;
          if (eng.ex_drop_i || !after.found) begin
            ready_d = 1'b1;
            drop_d  = eng.ex_drop_i;
            pkt_inc = 1'b1;
            state_d = S_DONE;
          end else begin
            k_d     = after.idx;
            mt_d    = NUM_STAGES'(1) << after.idx;
            state_d = S_MATCH;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!start_i) begin
          ready_d = 1'b0;
          drop_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase

    // A ready on the expiry cycle has already moved the state, so it wins.
    if (wd_expired && (state_d == state_q)) begin
      ps_d    = 1'b0;
      mt_d    = '0;
      ex_d    = 1'b0;
      error_d = 1'b1;
      err_inc = 1'b1;
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= S_FREE;
      k_q                   <= '0;
      eng.ps_start_o        <= 1'b0;
      eng.mt_start_o        <= '0;
      eng.ex_start_o        <= 1'b0;
      eng.ex_stage_o        <= '0;
      eng.ex_op_start_cnt_o <= '0;
      ready_o               <= 1'b0;
      drop_o                <= 1'b0;
      error_o               <= 1'b0;
      cfg_ack_o             <= 1'b0;
      pkt_cnt_o             <= '0;
      err_cnt_o             <= '0;
    end else begin
      state_q               <= state_d;
      k_q                   <= k_d;
      eng.ps_start_o        <= ps_d;
      eng.mt_start_o        <= mt_d;
      eng.ex_start_o        <= ex_d;
      eng.ex_stage_o        <= ex_stage_d;
      eng.ex_op_start_cnt_o <= ex_addr_d;
      ready_o               <= ready_d;
      drop_o                <= drop_d;
      error_o               <= error_d;
      cfg_ack_o             <= ack_d;
      if (pkt_inc) pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
      if (err_inc && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) tbl[i] <= '0;
    end else if (tbl_we) begin
      tbl[cfg_stage_i] <= '{en:        cfg_en_i,
                            hit_addr:  TBL_ADDR_W'(cfg_hit_addr_i),
                            miss_addr: TBL_ADDR_W'(cfg_miss_addr_i)};
    end
  end

endmodule
